// File: rtl/config_pkg.sv
// Shared encodings for the configuration frame sequencer: FSM states, bus owner
// codes and descriptor field layout.
package config_pkg;

    localparam int unsigned DataW        = 32;
    localparam int unsigned RowW         = 8;
    localparam int unsigned CountW       = 8;
    localparam int unsigned DescCountLsb = 0;
    localparam int unsigned DescRowLsb   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DESC  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } seqStateT;

    typedef logic [1:0] grantT;

    localparam grantT GrantNone = 2'b00;
    localparam grantT GrantUart = 2'b01;
    localparam grantT GrantBb   = 2'b10;

    function automatic logic [RowW-1:0] descRow(input logic [DataW-1:0] word);
        return word[DescRowLsb +: RowW];
    endfunction

    function automatic logic [CountW-1:0] descCount(input logic [DataW-1:0] word);
        return word[DescCountLsb +: CountW];
    endfunction

endpackage

// File: rtl/config_word_fifo.sv
// Small circular FIFO for frame words; full/empty are registered flags and a push
// into a full FIFO only succeeds when a pop happens in the same cycle.
module config_word_fifo #(
    parameter int unsigned Width = 45,
    parameter int unsigned Depth = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wrData,
    output logic [Width-1:0] rdData,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned PtrW1 = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW:0]    wrPtr;
    logic [PtrW:0]    rdPtr;
    logic [PtrW:0]    wrNext;
    logic [PtrW:0]    rdNext;
    logic             doPush;
    logic             doPop;

    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign rdData = mem[rdPtr[PtrW-1:0]];

    always_comb begin
        wrNext = wrPtr;
        rdNext = rdPtr;
        if (doPush) wrNext = wrPtr + PtrW1'(1);
        if (doPop)  rdNext = rdPtr + PtrW1'(1);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wrPtr <= '0;
            rdPtr <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            wrPtr <= wrNext;
            rdPtr <= rdNext;
            empty <= (wrNext == rdNext);
            full  <= (wrNext[PtrW] != rdNext[PtrW]) &&
                     (wrNext[PtrW-1:0] == rdNext[PtrW-1:0]);
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge CLK) begin
        if (doPush) mem[wrPtr[PtrW-1:0]] <= wrData;
    end

endmodule

// File: rtl/config_frame_sequencer.sv
// Arbitrates between the UART loader and the bitbang port, parses descriptor +
// data words and streams them to the fabric frame-write port through a FIFO.
module config_frame_sequencer
    import config_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FifoDepth       = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       UartActive,
    input  logic [DataW-1:0]           UartData,
    input  logic                       UartStrobe,
    input  logic                       BbActive,
    input  logic [DataW-1:0]           BbData,
    input  logic                       BbStrobe,
    input  logic                       FrameReady,
    output logic [DataW-1:0]           FrameData,
    output logic                       FrameStrobe,
    output logic [MaxFramesPerCol-1:0] FrameSelect,
    output logic [RowW-1:0]            RowSelect,
    output logic                       Busy,
    output grantT                      Grant,
    output logic                       Overflow,
    output logic                       ProtoError
);
    localparam int unsigned IdxW    = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
    localparam int unsigned EntryW  = DataW + RowW + IdxW;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(MaxFramesPerCol - 1);

    seqStateT          state;
    logic [CountW-1:0] remaining;
    logic [RowW-1:0]   curRow;
    logic [IdxW-1:0]   frameIdx;

    logic              ownerActive;
    logic              ownerStrobe;
    logic [DataW-1:0]  ownerData;

    logic              pushReq;
    logic              popReq;
    logic              pushOk;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [EntryW-1:0] wrEntry;
    logic [EntryW-1:0] rdEntry;
    logic [DataW-1:0]  headData;
    logic [RowW-1:0]   headRow;
    logic [IdxW-1:0]   headIdx;

    // Only the granted port is visible to the sequencer.
    always_comb begin
        ownerActive = 1'b0;
        ownerStrobe = 1'b0;
        ownerData   = '0;
        case (Grant)
            GrantUart: begin
                ownerActive = UartActive;
                ownerStrobe = UartStrobe;
                ownerData   = UartData;
            end
            GrantBb: begin
                ownerActive = BbActive;
                ownerStrobe = BbStrobe;
                ownerData   = BbData;
            end
            default: ;
        endcase
    end

    assign pushReq = (state == DATA) && ownerActive && ownerStrobe;
    assign popReq  = !fifoEmpty && FrameReady;
    assign pushOk  = pushReq && (!fifoFull || popReq);

    // Row and frame index ride along with each word so later descriptors cannot
    // retarget words that are still buffered.
    assign wrEntry = {ownerData, curRow, frameIdx};
    assign {headData, headRow, headIdx} = rdEntry;

    config_word_fifo #(
        .Width (EntryW),
        .Depth (FifoDepth)
    ) u_fifo (
        .CLK    (CLK),
        .RESET  (RESET),
        .push   (pushReq),
        .pop    (popReq),
        .wrData (wrEntry),
        .rdData (rdEntry),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            remaining   <= '0;
            curRow      <= '0;
            frameIdx    <= '0;
            Grant       <= GrantNone;
            Busy        <= 1'b0;
            Overflow    <= 1'b0;
            ProtoError  <= 1'b0;
            FrameData   <= '0;
            FrameStrobe <= 1'b0;
            FrameSelect <= '0;
            RowSelect   <= '0;
        end else begin
            FrameStrobe <= popReq;
            FrameSelect <= '0;
            if (popReq) begin
                FrameData   <= headData;
                RowSelect   <= headRow;
                FrameSelect <= MaxFramesPerCol'(1) << headIdx;
            end

            if (pushReq && fifoFull && !popReq) Overflow <= 1'b1;
            if (pushOk) frameIdx <= (frameIdx == LastIdx) ? '0 : frameIdx + IdxW'(1);

            case (state)
                IDLE: begin
                    if (UartActive || BbActive) begin
                        Grant      <= UartActive ? GrantUart : GrantBb;
                        state      <= DESC;
                        Busy       <= 1'b1;
                        Overflow   <= 1'b0;
                        ProtoError <= 1'b0;
                    end
                end
                DESC: begin
                    if (!ownerActive) begin
                        state <= DRAIN;
                    end else if (ownerStrobe) begin
                        curRow    <= descRow(ownerData);
                        remaining <= descCount(ownerData);
                        frameIdx  <= '0;
                        if (descCount(ownerData) != '0) state <= DATA;
                    end
                end
                DATA: begin
                    if (!ownerActive) begin
                        state      <= DRAIN;
                        ProtoError <= 1'b1;
                    end else if (ownerStrobe) begin
                        remaining <= remaining - CountW'(1);
                        if (remaining == CountW'(1)) state <= DESC;
                    end
                end
                DRAIN: begin
                    if (fifoEmpty) begin
                        state     <= IDLE;
                        Grant     <= GrantNone;
                        Busy      <= 1'b0;
                        remaining <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
